// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Optional statistics counters are enabled with the PC_SEQ_STATS_EN macro.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HOLD   = 2'd1,
      BUBBLE = 2'd2
   } pc_state_e;

   localparam int PC_STEP = 4;
   localparam int BUB_W   = 3;

endpackage

// File: rtl/pc_seq_stats.sv
// Saturating 32-bit redirect and bubble-cycle counters for pc_sequencer.
// Only instantiated when PC_SEQ_STATS_EN is defined.
module pc_seq_stats (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_inc,
   input  logic        bubble_inc,
   output logic [31:0] redirect_cnt,
   output logic [31:0] bubble_cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_cnt <= '0;
         bubble_cnt   <= '0;
      end else begin
         if (redirect_inc && (redirect_cnt != '1)) begin
            redirect_cnt <= redirect_cnt + 32'd1;
         end
         if (bubble_inc && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
         end
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, EX-stage redirects, stall deferral and bubbles.
// Define PC_SEQ_STATS_EN to build the redirect/bubble statistics counters.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int PC_W          = 9,
   parameter int BUBBLE_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            ex_valid_i,
   input  logic            pc_sel_i,
   input  logic [31:0]     br_pc_i,
   output logic [PC_W-1:0] pc_o,
   output logic            pc_valid_o,
   output logic            flush_o,
   output logic            misalign_o,
   output logic [31:0]     redirect_cnt_o,
   output logic [31:0]     bubble_cnt_o,
   output pc_state_e       state_o
);

   localparam logic [BUB_W-1:0] BUB_INIT = BUB_W'(BUBBLE_CYCLES);
   localparam logic [PC_W-1:0]  STEP     = PC_W'(PC_STEP);

   pc_state_e        state_q, state_d;
   logic [BUB_W-1:0] count_q, count_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [PC_W-1:0]  pend_q, pend_d;
   logic             misalign_q, misalign_d;
   logic             accept;
   logic             valid;
   logic [PC_W-1:0]  target;
   logic             unused_br_hi;

   // Word-aligned target; bits above PC_W only feed the lint sink below.
   assign target       = {br_pc_i[PC_W-1:2], 2'b00};
   assign unused_br_hi = ^br_pc_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         count_q    <= '0;
         pc_q       <= '0;
         pend_q     <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         pc_q       <= pc_d;
         pend_q     <= pend_d;
         misalign_q <= misalign_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      pc_d       = pc_q;
      pend_d     = pend_q;
      accept     = 1'b0;
      valid      = 1'b0;
      misalign_d = 1'b0;

      case (state_q)
         RUN: begin
            valid = 1'b1;
            if (ex_valid_i && pc_sel_i) begin
               accept     = 1'b1;
               misalign_d = (br_pc_i[1:0] != 2'b00);
               if (stall_i) begin
                  pend_d  = target;
                  state_d = HOLD;
               end else begin
                  pc_d    = target;
                  state_d = (BUBBLE_CYCLES == 0) ? RUN : BUBBLE;
                  count_d = BUB_INIT;
               end
            end else if (!stall_i) begin
               pc_d = pc_q + STEP;
            end
         end

         HOLD: begin
            if (!stall_i) begin
               pc_d    = pend_q;
               state_d = (BUBBLE_CYCLES == 0) ? RUN : BUBBLE;
               count_d = BUB_INIT;
            end
         end

         BUBBLE: begin
            count_d = count_q - 1'b1;
            if (count_q <= BUB_W'(1)) begin
               state_d = RUN;
            end
         end

         default: begin
            state_d = RUN;
         end
      endcase
   end

   assign pc_o       = pc_q;
   assign pc_valid_o = valid;
   assign flush_o    = accept;
   assign misalign_o = misalign_q;
   assign state_o    = state_q;

   // The EX stage is expected to be frozen while a deferred redirect waits.
   redirect_in_hold: assert property (
      @(posedge clk) disable iff (!rst_n)
      !((state_q == HOLD) && ex_valid_i && pc_sel_i)
   );

`ifdef PC_SEQ_STATS_EN
   pc_seq_stats u_stats (
      .clk          (clk),
      .rst_n        (rst_n),
      .redirect_inc (accept),
      .bubble_inc   (!valid),
      .redirect_cnt (redirect_cnt_o),
      .bubble_cnt   (bubble_cnt_o)
   );
`else
   assign redirect_cnt_o = '0;
   assign bubble_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: behavioural reference model feeding an expected queue.
// Works with or without PC_SEQ_STATS_EN defined.
module tb_pc_sequencer;
   import pc_seq_pkg::*;

   localparam int PC_W = 9;
   localparam int BUB  = 1;
   localparam int EW   = PC_W + 5;
`ifdef PC_SEQ_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            stall_i = 1'b0;
   logic            ex_valid_i = 1'b0;
   logic            pc_sel_i = 1'b0;
   logic [31:0]     br_pc_i = '0;
   logic [PC_W-1:0] pc_o;
   logic            pc_valid_o;
   logic            flush_o;
   logic            misalign_o;
   logic [31:0]     redirect_cnt_o;
   logic [31:0]     bubble_cnt_o;
   pc_state_e       state_o;

   pc_sequencer #(.PC_W(PC_W), .BUBBLE_CYCLES(BUB)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall_i        (stall_i),
      .ex_valid_i     (ex_valid_i),
      .pc_sel_i       (pc_sel_i),
      .br_pc_i        (br_pc_i),
      .pc_o           (pc_o),
      .pc_valid_o     (pc_valid_o),
      .flush_o        (flush_o),
      .misalign_o     (misalign_o),
      .redirect_cnt_o (redirect_cnt_o),
      .bubble_cnt_o   (bubble_cnt_o),
      .state_o        (state_o)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [EW-1:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // mode: 0 = fetching, 1 = waiting out a stall with a pending target, 2 = bubbles
   int m_pc, m_mode, m_left, m_pend, m_redirs, m_bubs;
   bit m_mis;

   function automatic void model_reset();
      m_pc = 0; m_mode = 0; m_left = 0; m_pend = 0;
      m_mis = 0; m_redirs = 0; m_bubs = 0;
   endfunction

   function automatic void model_go(input int tgt);
      m_pc = tgt;
      if (BUB == 0) m_mode = 0;
      else begin
         m_mode = 2;
         m_left = BUB;
      end
   endfunction

   // Called just after a falling edge: drive, check, advance model, wait for next falling edge.
   task automatic step(input bit stall, input bit exv, input bit sel, input logic [31:0] br);
      logic [EW-1:0] e;
      bit e_valid, e_flush;
      logic [1:0] e_state;
      int tgt;
      stall_i = stall; ex_valid_i = exv; pc_sel_i = sel; br_pc_i = br;
      e_valid = (m_mode == 0);
      e_flush = e_valid && exv && sel;
      e_state = (m_mode == 0) ? 2'd0 : (m_mode == 1) ? 2'd1 : 2'd2;
      exp_q.push_back({PC_W'(m_pc), e_valid, e_flush, m_mis, e_state});
      #1;
      e = exp_q.pop_front();
      check_eq("pc", pc_o, e[EW-1:5]);
      check_eq("pc_valid", pc_valid_o, e[4]);
      check_eq("flush", flush_o, e[3]);
      check_eq("misalign", misalign_o, e[2]);
      check_eq("state", state_o, e[1:0]);
      check_eq("redirect_cnt", redirect_cnt_o, STATS ? m_redirs : 0);
      check_eq("bubble_cnt", bubble_cnt_o, STATS ? m_bubs : 0);
      m_mis = e_flush && (br[1:0] != 2'b00);
      if (!e_valid) m_bubs++;
      if (e_flush) m_redirs++;
      tgt = int'(br % (32'd1 << PC_W)) & ~3;
      case (m_mode)
         0: begin
            if (e_flush) begin
               if (stall) begin
                  m_pend = tgt;
                  m_mode = 1;
               end else model_go(tgt);
            end else if (!stall) m_pc = (m_pc + 4) % (1 << PC_W);
         end
         1: if (!stall) model_go(m_pend);
         default: begin
            m_left--;
            if (m_left == 0) m_mode = 0;
         end
      endcase
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; stall_i = 1'b0; ex_valid_i = 1'b0; pc_sel_i = 1'b0; br_pc_i = '0;
      #1;
      check_eq("rst_pc", pc_o, 0);
      check_eq("rst_valid", pc_valid_o, 1);
      check_eq("rst_flush", flush_o, 0);
      check_eq("rst_misalign", misalign_o, 0);
      check_eq("rst_redirect_cnt", redirect_cnt_o, 0);
      check_eq("rst_bubble_cnt", bubble_cnt_o, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0);
   endtask

   initial begin
      bit st, ev, sl;
      model_reset();
      @(negedge clk);
      apply_reset();

      // Sequential fetch through the 9-bit wrap.
      idle(127);
      check_eq("pre_wrap_pc", pc_o, 32'h1FC);
      idle(3);
      check_eq("post_wrap_pc", pc_o, 32'h008);

      // Taken branch at pc 0x010 with no stall.
      apply_reset();
      idle(4);
      step(0, 1, 1, 32'h0000_0080);
      step(0, 1, 1, 32'h0000_0200);  // ignored while bubbling
      idle(3);

      // Not-taken and invalid-EX cases leave sequencing alone.
      step(0, 1, 0, 32'h0000_0100);
      step(0, 0, 1, 32'h0000_0100);

      // Redirect deferred by a 3-cycle stall.
      step(1, 1, 1, 32'h0000_0040);
      step(1, 0, 0, 32'h0);
      step(1, 0, 0, 32'h0);
      step(0, 0, 0, 32'h0);
      step(1, 0, 0, 32'h0);  // stall ignored in BUBBLE
      idle(3);

      // Misaligned target with high bits set.
      step(0, 1, 1, 32'hFFFF_F0C6);
      check_eq("misalign_target_pc", pc_o, 32'h0C4);
      idle(3);

      // Reset mid-BUBBLE.
      step(0, 1, 1, 32'h0000_0120);
      apply_reset();
      idle(3);

      // Reset mid-HOLD: the pending target must not resurface.
      step(1, 1, 1, 32'h0000_0150);
      step(1, 0, 0, 32'h0);
      apply_reset();
      idle(4);

      // Three redirects for the statistics counters.
      apply_reset();
      for (int r = 0; r < 3; r++) begin
         step(0, 1, 1, 32'h0000_0100 + 32'(r * 16));
         idle(BUB + 1);
      end
      check_eq("stats_redirects", redirect_cnt_o, STATS ? 32'd3 : 32'd0);
      check_eq("stats_bubbles", bubble_cnt_o, STATS ? 32'(3 * BUB) : 32'd0);

      // Random traffic; no redirect is offered while a target is pending.
      for (int i = 0; i < 300; i++) begin
         st = ($urandom_range(0, 3) == 0);
         ev = ($urandom_range(0, 2) == 0);
         sl = ($urandom_range(0, 1) == 1) && (m_mode != 1);
         step(st, ev, sl, $urandom());
      end
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
